// File: rtl/a2d_spi_resp_if.sv
// SPI pin bundle between an A2D_intf-style master and the a2d_spi_resp responder.
`timescale 1ns/1ps
interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating the 8-channel 12-bit A2D: frame N addresses a channel, frame N+1 returns it.
// Optional macro A2D_MISO_TRISTATE_EN releases MISO (1'bz) whenever the responder is not selected.
`timescale 1ns/1ps
module a2d_spi_resp #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  a2d_spi_resp_if.slave     spi,
  input  logic              wr_en,
  input  logic [2:0]        wr_chnl,
  input  logic [DATA_W-1:0] wr_data,
  output logic              cmd_vld,
  output logic [2:0]        cmd_addr,
  output logic              frm_err
);

  localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 2);
  localparam int unsigned RX_W   = FRAME_BITS - 2;
  localparam int unsigned NUM_CH = 8;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_d, sclk_d;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [DATA_W-1:0]     table_q [NUM_CH];
  logic [FRAME_BITS-1:0] tx_q;
  logic [RX_W-1:0]       rx_q;
  logic [CNT_W-1:0]      cnt_q;

  logic load_tx, tx_shift, rx_shift, end_ok, end_err;

  // Pin synchronizers; SS_n chain resets low so a frame cut by reset is not mistaken for a new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '0;
      sclk_sync <= '1;
      mosi_sync <= '0;
      ss_d      <= 1'b0;
      sclk_d    <= 1'b1;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  // Sample table written from the parallel port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_chnl] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_tx  = 1'b0;
    tx_shift = 1'b0;
    rx_shift = 1'b0;
    end_ok   = 1'b0;
    end_err  = 1'b0;
    case (state_q)
      WAIT_IDLE: if (ss_s) state_d = IDLE;
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          load_tx = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_W'(FRAME_BITS)) end_ok  = 1'b1;
          else                             end_err = 1'b1;
        end else begin
          rx_shift = sclk_rise;
          // The master's leading fall precedes any rise and must not consume the MSB
          tx_shift = sclk_fall && (cnt_q != '0);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q     <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      cmd_addr <= '0;
      cmd_vld  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      cmd_vld <= end_ok;
      frm_err <= end_err;
      if (end_ok) cmd_addr <= rx_q[RX_W-1 -: 3];
      if (load_tx) begin
        tx_q  <= FRAME_BITS'(table_q[cmd_addr]);
        cnt_q <= '0;
      end else begin
        if (tx_shift) tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
        if (rx_shift) begin
          rx_q <= {rx_q[RX_W-2:0], mosi_s};
          if (cnt_q != CNT_W'(FRAME_BITS + 1)) cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef A2D_MISO_TRISTATE_EN
  assign spi.MISO = (ss_s || (state_q != ACTIVE)) ? 1'bz : tx_q[FRAME_BITS-1];
`else
  assign spi.MISO = (state_q == ACTIVE) ? tx_q[FRAME_BITS-1] : 1'b0;
`endif

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Scoreboard bench for a2d_spi_resp: a bit-banged SPI master feeds frames, a monitor checks words and pulses.
`timescale 1ns/1ps
module tb_a2d_spi_resp;

  localparam int HALF = 16;  // SCLK = clk/32

`ifdef A2D_MISO_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  typedef struct packed {
    logic       err;
    logic [2:0] addr;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_chnl;
  logic [11:0] wr_data;
  logic        cmd_vld;
  logic [2:0]  cmd_addr;
  logic        frm_err;

  a2d_spi_resp_if spi ();

  a2d_spi_resp u_dut (
    .clk      (clk),
    .rst      (rst),
    .spi      (spi),
    .wr_en    (wr_en),
    .wr_chnl  (wr_chnl),
    .wr_data  (wr_data),
    .cmd_vld  (cmd_vld),
    .cmd_addr (cmd_addr),
    .frm_err  (frm_err)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_word_q[$];
  logic [15:0] got_word_q[$];
  evt_t        exp_evt_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] mdl [8];
  logic [2:0]  mdl_addr;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: compares returned words and cmd_vld/frm_err pulses against the expectation queues
  always @(negedge clk) begin
    logic [15:0] g;
    evt_t        ev;
    if (got_word_q.size() > 0) begin
      g = got_word_q.pop_front();
      if (exp_word_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL miso_word: got %h, expected none", g);
      end else begin
        check("miso_word", g, exp_word_q.pop_front());
      end
    end
    if (!rst && (cmd_vld || frm_err)) begin
      if (exp_evt_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL event: got vld=%b err=%b addr=%0d, expected no event", cmd_vld, frm_err, cmd_addr);
      end else begin
        ev = exp_evt_q.pop_front();
        check("cmd_vld", 16'(cmd_vld), 16'(!ev.err));
        check("frm_err", 16'(frm_err), 16'(ev.err));
        check("cmd_addr", 16'(cmd_addr), 16'(ev.addr));
      end
    end
  end

  task automatic wr(input logic [2:0] ch, input logic [11:0] v);
    wr_en = 1'b1; wr_chnl = ch; wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
    mdl[ch] = v;
  endtask

  task automatic frame(input logic [15:0] mosi, input int nbits, input int rst_at,
                       input int wr_at, input logic [2:0] wr_ch, input logic [11:0] wr_v,
                       output logic [15:0] got);
    got = '0;
    spi.SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.SCLK = 1'b0;
      spi.MOSI = mosi[15-i];
      repeat (HALF) @(negedge clk);
      spi.SCLK = 1'b1;
      got[15-i] = spi.MISO;
      repeat (HALF) @(negedge clk);
      if (i + 1 == rst_at) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
      if (i + 1 == wr_at) wr(wr_ch, wr_v);
    end
    spi.SS_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic run(input logic [15:0] mosi, input logic [15:0] exp_word, input logic [2:0] exp_addr,
                     input int wr_at, input logic [2:0] wr_ch, input logic [11:0] wr_v);
    logic [15:0] got;
    exp_word_q.push_back(exp_word);
    exp_evt_q.push_back('{1'b0, exp_addr});
    frame(mosi, 16, -1, wr_at, wr_ch, wr_v, got);
    got_word_q.push_back(got);
    mdl_addr = exp_addr;
  endtask

  task automatic run_mdl(input logic [15:0] mosi);
    run(mosi, {4'h0, mdl[mdl_addr]}, mosi[13:11], -1, 3'd0, 12'd0);
  endtask

  logic [15:0] t1_mosi [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h0000};
  logic [15:0] t1_word [4] = '{16'h0400, 16'h0400, 16'h03FF, 16'h0FFE};
  logic [2:0]  t1_addr [4] = '{3'd0, 3'd4, 3'd5, 3'd0};

  initial begin
    logic [15:0] got;
    rst = 1'b1; spi.SS_n = 1'b1; spi.SCLK = 1'b1; spi.MOSI = 1'b0;
    wr_en = 1'b0; wr_chnl = '0; wr_data = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    mdl_addr = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_cmd_addr", 16'(cmd_addr), 16'h0);
    check("rst_cmd_vld", 16'(cmd_vld), 16'h0);
    check("rst_frm_err", 16'(frm_err), 16'h0);
    check("rst_miso", 16'(spi.MISO), 16'(IDLE_MISO));

    // Basic address/return pipeline
    wr(3'd0, 12'h400); wr(3'd4, 12'h3FF); wr(3'd5, 12'hFFE);
    for (int i = 0; i < 4; i++) run(t1_mosi[i], t1_word[i], t1_addr[i], -1, 3'd0, 12'd0);
    check("idle_miso", 16'(spi.MISO), 16'(IDLE_MISO));

    // Short frame: error pulse, address kept
    exp_evt_q.push_back('{1'b1, mdl_addr});
    frame(16'h2800, 8, -1, -1, 3'd0, 12'd0, got);
    run(16'h2000, 16'h0400, 3'd4, -1, 3'd0, 12'd0);

    // Write during a frame returning ch4 only shows up in the next frame
    run(16'h2000, 16'h03FF, 3'd4, 8, 3'd4, 12'h123);
    run(16'h2000, 16'h0123, 3'd4, -1, 3'd0, 12'd0);

    // Reset after bit 6: top six bits of 0x0FFF, zeros afterwards, no event
    wr(3'd4, 12'hFFF);
    exp_word_q.push_back(16'h0C00);
    frame(16'h2800, 16, 6, -1, 3'd0, 12'd0, got);
    got_word_q.push_back(got);
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    mdl_addr = '0;
    check("post_rst_cmd_addr", 16'(cmd_addr), 16'h0);
    check("post_rst_miso", 16'(spi.MISO), 16'(IDLE_MISO));
    run(16'h2800, 16'h0000, 3'd5, -1, 3'd0, 12'd0);
    run(16'h0000, 16'h0000, 3'd0, -1, 3'd0, 12'd0);

    // Decrementing table with wrap-around through zero
    wr(3'd0, 12'h008); wr(3'd4, 12'h006); wr(3'd5, 12'h002);
    for (int it = 0; it < 6; it++) begin
      wr(3'd0, 12'(mdl[0] - 12'd4));
      wr(3'd4, 12'(mdl[4] - 12'd3));
      wr(3'd5, 12'(mdl[5] - 12'd1));
      run_mdl(16'h2000);
      run_mdl(16'h2800);
      run_mdl(16'h0000);
    end
    check("final_ch0", 16'(mdl[0]), 16'h0FF0);

    repeat (100) @(negedge clk);
    check("words_drained", 16'(exp_word_q.size()), 16'h0);
    check("events_drained", 16'(exp_evt_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
